pipe_share_ctrl: RTL
====================

# pipe_share_ctrl

Controller that shares one DEPTH-stage WIDTH-bit register pipeline between two requesters. This is the pipeline structure exercised by the blocking/non-blocking comparison benches (input `a`, stage `b`, stage `c`). Round-robin arbitration selects the requester, and a valid/ready handshake loads the winner into stage 0. Each entry carries a source tag to the output, and the controller provides flush, drain sequencing and occupancy reporting. It sits between the stimulus sources and the shift datapath.

## Interface
Parameters:
- WIDTH, 4, data width of each pipeline entry
- DEPTH, 2, number of pipeline stages (legal range 2..8)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has data
- req0_data  in  WIDTH  requester 0 data
- req0_ready  out  1  requester 0 accepted this cycle when high with req0_valid
- req1_valid  in  1  requester 1 has data
- req1_data  in  WIDTH  requester 1 data
- req1_ready  out  1  requester 1 accepted this cycle
- flush  in  1  synchronous clear of all pipeline entries
- drain  in  1  level request: stop accepting and empty the pipeline
- drain_done  out  1  high in DRAIN while the pipeline is empty
- out_valid  out  1  last stage holds a valid entry
- out_data  out  WIDTH  last-stage data
- out_src  out  1  requester id of the last-stage entry
- out_ready  in  1  consumer accepts the output
- count  out  $clog2(DEPTH+1)  number of valid entries in the pipeline

## Operation
- Each stage holds {valid, src, data}. Stage i+1 takes stage i on advance, and stage 0 takes the granted request.
- stall = out_valid & ~out_ready. advance = ~stall. When stalled, all stages hold. There is no bubble squeezing.
- Arbitration is combinational round-robin on a registered last_grant bit, reset to 1 so requester 0 wins first.
  - When only one requester is valid, that requester wins.
  - When both are valid, the requester that is not last_grant wins.
  - last_grant updates only on an accepted transfer.
- reqN_ready = grantN & advance & ~flush & (state == RUN). No ready is asserted when the requester is not valid.
- When nothing is accepted on advance, stage 0 loads valid=0.
- FSM states: RUN and DRAIN.
  - RUN -> DRAIN when drain = 1.
  - DRAIN -> RUN when drain = 0.
  - In DRAIN, no grants are made, the pipeline keeps advancing, and drain_done = (count == 0).
- flush takes priority over everything else. At the next edge it clears every valid bit. Data and src are don't-care, and last_grant and the FSM state are unchanged.
- count is registered: +1 on accept, -1 on output pop (out_valid & out_ready), net 0 when both happen. On flush it goes to 0.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, count=0, state=RUN, last_grant=1, all stage valid bits 0.
  - reqN_ready and drain_done are 0 while in reset.
- Latency: an entry accepted at edge k appears on out_* after edge k+DEPTH-1. With DEPTH=2, data is visible 2 cycles after the accept cycle, the same as the `c` stage.
- Throughput is one entry per cycle with no stall.
- Simultaneous events:
  - flush together with an accept handshake: no accept (ready is low).
  - flush together with a pop: the entry is treated as consumed and count goes to 0.
  - drain rising together with valid requests: no grant in that cycle is not required; the FSM change takes effect from the next cycle.
- Reset asserted mid-operation clears everything asynchronously. In-flight entries are lost.
- count never exceeds DEPTH.

## Structure
- Package pipe_share_pkg: state enum (ST_RUN, ST_DRAIN), src_t (1-bit), stage record typedef {valid, src, data}.
- Sub-module pipe_stage: one register stage with inputs en and clr, async reset. Instantiate DEPTH copies in a generate loop.
- The arbiter, FSM and counter live in the top module.

## Test plan
- Reset, then req0 sends 4'h3 alone with out_ready=1 -> out_valid=1, out_data=3, out_src=0 two cycles after the accept; count goes 1 then back to 0.
- Both requesters continuously valid (req0=4'h7, req1=4'hf) -> grants alternate 0,1,0,1 and the output stream is 7,f,7,f with src 0,1,0,1.
- out_ready held low for 3 cycles with both stages full -> both ready signals are low, out_data is held, count=2; on release the stream resumes with no loss or duplication.
- flush asserted with 2 entries in flight -> next cycle out_valid=0 and count=0; last_grant is preserved, so the next grant goes to the other requester.
- drain asserted with entries 4'ha and 4'h2 in flight -> no new accepts, both entries exit, then drain_done=1; drain deasserted -> grants resume the next cycle.
- rst_n pulsed low mid-stream -> all outputs return to their reset values immediately; after release, req0 wins first.

Source files
------------

// File: rtl/pipe_share_pkg.sv
// Shared types for the two-requester pipeline controller: FSM states, source tag,
// per-stage tag record and the round-robin pick helper.
package pipe_share_pkg;

  typedef enum logic [0:0] {ST_RUN, ST_DRAIN} state_e;

  typedef logic src_t;

  // Data is carried alongside the tag so the record width follows the instance WIDTH.
  typedef struct packed {
    logic valid;
    src_t src;
  } stage_tag_t;

  // Single valid requester wins outright; on contention the one not granted last wins.
  function automatic src_t rr_pick(logic v0, logic v1, src_t last_grant);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    return ~last_grant;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register stage holding {valid, src, data}; clr drops the valid bit
// and wins over en.
module pipe_stage
  import pipe_share_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  stage_tag_t       d_tag,
  input  logic [WIDTH-1:0] d_data,
  output stage_tag_t       q_tag,
  output logic [WIDTH-1:0] q_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_tag  <= '0;
      q_data <= '0;
    end else if (clr) begin
      q_tag.valid <= 1'b0;
    end else if (en) begin
      q_tag  <= d_tag;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_share_ctrl.sv
// Shares one DEPTH-stage pipeline between two requesters: round-robin arbitration,
// valid/ready load into stage 0, flush, drain sequencing and occupancy count.
module pipe_share_ctrl
  import pipe_share_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req0_valid,
  input  logic [WIDTH-1:0]             req0_data,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [WIDTH-1:0]             req1_data,
  output logic                         req1_ready,
  input  logic                         flush,
  input  logic                         drain,
  output logic                         drain_done,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_src,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  src_t             last_grant_q, last_grant_d;
  logic [CW-1:0]    count_q, count_d;

  stage_tag_t       tag_q  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  stage_tag_t       in_tag;
  logic [WIDTH-1:0] in_data;
  src_t             win;
  logic             advance, accept, pop, load_ok;

  assign out_valid = tag_q[DEPTH-1].valid;
  assign out_src   = tag_q[DEPTH-1].src;
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

  always_comb begin
    advance = ~(out_valid & ~out_ready);
    win     = rr_pick(req0_valid, req1_valid, last_grant_q);
    // rst_n gating keeps ready low while reset is held.
    load_ok = advance & ~flush & (state_q == ST_RUN) & rst_n;

    req0_ready = req0_valid & (win == 1'b0) & load_ok;
    req1_ready = req1_valid & (win == 1'b1) & load_ok;
    accept     = req0_ready | req1_ready;
    pop        = out_valid & out_ready;

    in_tag.valid = accept;
    in_tag.src   = win;
    in_data      = win ? req1_data : req0_data;

    last_grant_d = accept ? win : last_grant_q;

    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(accept) - CW'(pop);
    end

    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (drain)  state_d = ST_DRAIN;
      ST_DRAIN: if (!drain) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    drain_done = (state_q == ST_DRAIN) && (count_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      last_grant_q <= 1'b1;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (advance),
        .clr    (flush),
        .d_tag  (in_tag),
        .d_data (in_data),
        .q_tag  (tag_q[i]),
        .q_data (data_q[i])
      );
    end else begin : g_body
      pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (advance),
        .clr    (flush),
        .d_tag  (tag_q[i-1]),
        .d_data (data_q[i-1]),
        .q_tag  (tag_q[i]),
        .q_data (data_q[i])
      );
    end
  end

endmodule
